// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map and write op codes.
package irq_pkg;

   // Register addresses shared by the write and read ports
   localparam logic [1:0] REG_MASK     = 2'd0;
   localparam logic [1:0] REG_MODE     = 2'd1;
   localparam logic [1:0] REG_POLARITY = 2'd2;
   localparam logic [1:0] REG_PENDING  = 2'd3;

   // Write operations applied to the addressed register
   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_SET   = 2'd1;
   localparam logic [1:0] OP_CLEAR = 2'd2;
   localparam logic [1:0] OP_XOR   = 2'd3;

   // Upper bound on the number of interrupt sources
   localparam int unsigned MAX_CHANNELS = 32;

endpackage

// File: rtl/irq_controller_if.sv
// Software register port, raw interrupt sources and CPU-side request outputs.
interface irq_controller_if #(
   parameter int CHANNELS = 8,
   parameter int VW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic [CHANNELS-1:0] irq_in;
   logic                wr_en;
   logic [1:0]          wr_addr;
   logic [1:0]          wr_op;
   logic [CHANNELS-1:0] wr_data;
   logic [1:0]          rd_addr;
   logic [CHANNELS-1:0] rd_data;
   logic                ack;
   logic                irq_out;
   logic [VW-1:0]       irq_vector;

   // Peripheral / CPU side driving the controller
   modport master (
      output irq_in, wr_en, wr_addr, wr_op, wr_data, rd_addr, ack,
      input  rd_data, irq_out, irq_vector
   );

   // The controller itself
   modport slave (
      input  irq_in, wr_en, wr_addr, wr_op, wr_data, rd_addr, ack,
      output rd_data, irq_out, irq_vector
   );
endinterface

// File: rtl/irq_channel.sv
// One interrupt channel: synchroniser, polarity adjust, edge history and sticky pending flop.
// Level channels report the history flop so both modes see the same input latency.
module irq_channel #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic irq_raw_i,
   input  logic polarity_i,
   input  logic mode_i,
   input  logic sw_set_i,
   input  logic sw_clr_i,
   input  logic ack_clr_i,
   input  logic mode_clr_i,
   output logic pending_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   hist_q;
   logic                   hist_d;
   logic                   pend_q;
   logic                   pend_d;
   logic                   active_s;
   logic                   edge_s;

   // Next-state: shift synchroniser, detect rising active edge, resolve pending priorities
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], irq_raw_i};
      active_s = sync_q[SYNC_STAGES-1] ^ polarity_i;
      edge_s   = active_s & ~hist_q;
      hist_d   = active_s;
      // Mode change beats a fresh edge; a fresh edge beats any clear so no event is lost
      if (mode_clr_i || !mode_i) begin
         pend_d = 1'b0;
      end else if (edge_s) begin
         pend_d = 1'b1;
      end else if (sw_set_i) begin
         pend_d = 1'b1;
      end else if (sw_clr_i || ack_clr_i) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
   end

   // Channel state flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
         pend_q <= pend_d;
      end
   end

   assign pending_o = mode_i ? pend_q : hist_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller top: config registers with op-based writes, per-channel
// capture, read mux, priority encoder and registered CPU request outputs.
module irq_controller
   import irq_pkg::*;
#(
   parameter int CHANNELS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   irq_controller_if.slave  bus
);
   localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0] mask_q, mask_d;
   logic [CHANNELS-1:0] mode_q, mode_d;
   logic [CHANNELS-1:0] pol_q, pol_d;
   logic [CHANNELS-1:0] sw_set_s, sw_clr_s, ack_clr_s, mode_clr_s;
   logic [CHANNELS-1:0] pending_s;
   logic [CHANNELS-1:0] request_s;
   logic                irq_out_q, irq_out_d;
   logic [VW-1:0]       irq_vector_q, irq_vector_d;

   // Register write ALU: load / set / clear / toggle
   function automatic logic [CHANNELS-1:0] apply_op(input logic [1:0] op,
                                                    input logic [CHANNELS-1:0] old_v,
                                                    input logic [CHANNELS-1:0] data_v);
      case (op)
         OP_LOAD:  apply_op = data_v;
         OP_SET:   apply_op = old_v | data_v;
         OP_CLEAR: apply_op = old_v & ~data_v;
         OP_XOR:   apply_op = old_v ^ data_v;
         default:  apply_op = old_v;
      endcase
   endfunction

   // Index of the highest set request bit, zero when none
   function automatic logic [VW-1:0] prio_enc(input logic [CHANNELS-1:0] req);
      prio_enc = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (req[i]) begin
            prio_enc = VW'(i);
         end else begin
            prio_enc = prio_enc;
         end
      end
   endfunction

   // Decode software writes into config next-state and per-channel pending strobes
   always_comb begin
      mask_d   = mask_q;
      mode_d   = mode_q;
      pol_d    = pol_q;
      sw_set_s = '0;
      sw_clr_s = '0;
      if (bus.wr_en) begin
         case (bus.wr_addr)
            REG_MASK:     mask_d = apply_op(bus.wr_op, mask_q, bus.wr_data);
            REG_MODE:     mode_d = apply_op(bus.wr_op, mode_q, bus.wr_data);
            REG_POLARITY: pol_d  = apply_op(bus.wr_op, pol_q, bus.wr_data);
            REG_PENDING: begin
               // Only edge channels hold state; LOAD and XOR do nothing here
               case (bus.wr_op)
                  OP_SET:   sw_set_s = bus.wr_data & mode_q;
                  OP_CLEAR: sw_clr_s = bus.wr_data & mode_q;
                  default:  sw_set_s = '0;
               endcase
            end
            default: mask_d = mask_q;
         endcase
      end else begin
         mask_d = mask_q;
      end
      mode_clr_s = mode_d ^ mode_q;
   end

   // Acknowledge clears the presented channel only while a request is shown
   always_comb begin
      ack_clr_s = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (bus.ack && irq_out_q && (irq_vector_q == VW'(i))) begin
            ack_clr_s[i] = mode_q[i];
         end else begin
            ack_clr_s[i] = 1'b0;
         end
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      irq_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
         .clk        (clk),
         .rst        (rst),
         .irq_raw_i  (bus.irq_in[gi]),
         .polarity_i (pol_q[gi]),
         .mode_i     (mode_q[gi]),
         .sw_set_i   (sw_set_s[gi]),
         .sw_clr_i   (sw_clr_s[gi]),
         .ack_clr_i  (ack_clr_s[gi]),
         .mode_clr_i (mode_clr_s[gi]),
         .pending_o  (pending_s[gi])
      );
   end

   // Masked request and next values of the CPU-facing outputs
   always_comb begin
      request_s    = pending_s & mask_q;
      irq_out_d    = |request_s;
      irq_vector_d = prio_enc(request_s);
   end

   // Read mux; pending is shown unmasked
   always_comb begin
      case (bus.rd_addr)
         REG_MASK:     bus.rd_data = mask_q;
         REG_MODE:     bus.rd_data = mode_q;
         REG_POLARITY: bus.rd_data = pol_q;
         REG_PENDING:  bus.rd_data = pending_s;
         default:      bus.rd_data = '0;
      endcase
   end

   // Config registers and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q       <= '0;
         mode_q       <= '0;
         pol_q        <= '0;
         irq_out_q    <= 1'b0;
         irq_vector_q <= '0;
      end else begin
         mask_q       <= mask_d;
         mode_q       <= mode_d;
         pol_q        <= pol_d;
         irq_out_q    <= irq_out_d;
         irq_vector_q <= irq_vector_d;
      end
   end

   assign bus.irq_out    = irq_out_q;
   assign bus.irq_vector = irq_vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// traffic compared every cycle against a cycle-level behavioural model.
module tb_irq_controller;
   localparam int CH   = 8;
   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   irq_controller_if #(.CHANNELS(CH)) bus ();

   irq_controller #(.CHANNELS(CH), .SYNC_STAGES(SYNC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [CH-1:0] m_mask, m_mode, m_pol, m_ep, m_lvl, m_eff;
   logic          m_out;
   logic [2:0]    m_vec;
   logic [CH-1:0] dq[$];

   function automatic logic [CH-1:0] op_apply(input logic [1:0] op, input logic [CH-1:0] o, input logic [CH-1:0] d);
      case (op)
         2'd0: return d;
         2'd1: return o | d;
         2'd2: return o & ~d;
         default: return o ^ d;
      endcase
   endfunction

   function automatic logic [2:0] highest(input logic [CH-1:0] r);
      for (int i = CH - 1; i >= 0; i--) if (r[i]) return 3'(i);
      return 3'd0;
   endfunction

   // Model advances on every clock edge from the stimulus the DUT also sees
   always @(posedge clk or posedge rst) begin : mdl
      logic [CH-1:0] req, a, edg, ackc, sset, sclr, nmask, nmode, npol;
      if (rst) begin
         m_mask = '0; m_mode = '0; m_pol = '0; m_ep = '0; m_lvl = '0; m_eff = '0;
         m_out = 1'b0; m_vec = 3'd0;
         dq.delete();
         for (int i = 0; i < SYNC; i++) dq.push_back('0);
      end else begin
         req  = m_eff & m_mask;
         a    = dq[SYNC-1] ^ m_pol;
         edg  = a & ~m_lvl & m_mode;
         ackc = (bus.ack && m_out) ? ((CH'(1) << m_vec) & m_mode) : '0;
         sset = '0; sclr = '0;
         nmask = m_mask; nmode = m_mode; npol = m_pol;
         if (bus.wr_en) begin
            case (bus.wr_addr)
               2'd0: nmask = op_apply(bus.wr_op, m_mask, bus.wr_data);
               2'd1: nmode = op_apply(bus.wr_op, m_mode, bus.wr_data);
               2'd2: npol  = op_apply(bus.wr_op, m_pol, bus.wr_data);
               default: begin
                  if (bus.wr_op == 2'd1) sset = bus.wr_data & m_mode;
                  if (bus.wr_op == 2'd2) sclr = bus.wr_data & m_mode;
               end
            endcase
         end
         m_ep  = ((m_ep & ~(sclr | ackc)) | sset | edg) & ~(nmode ^ m_mode) & nmode;
         m_lvl = a;
         m_mask = nmask; m_mode = nmode; m_pol = npol;
         m_eff = (m_ep & m_mode) | (m_lvl & ~m_mode);
         m_out = |req;
         m_vec = highest(req);
         void'(dq.pop_back());
         dq.push_front(bus.irq_in);
      end
   end

   function automatic logic [CH-1:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0: return m_mask;
         2'd1: return m_mode;
         2'd2: return m_pol;
         default: return m_eff;
      endcase
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      chk("irq_out", 32'(bus.irq_out), 32'(m_out));
      chk("irq_vector", 32'(bus.irq_vector), 32'(m_vec));
      chk("rd_data", 32'(bus.rd_data), 32'(model_rd(bus.rd_addr)));
   endtask

   task automatic wr(input logic [1:0] addr, input logic [1:0] op, input logic [CH-1:0] data);
      bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_op = op; bus.wr_data = data;
      step();
      bus.wr_en = 1'b0;
   endtask

   // Steps until irq_out reaches lvl; returns edges taken (bounded)
   task automatic edges_until(input logic lvl, input int drop_at, output int cnt);
      cnt = 0;
      while (bus.irq_out !== lvl && cnt < 20) begin
         step();
         cnt++;
         if (cnt == drop_at) bus.irq_in = '0;
      end
   endtask

   initial begin
      int cnt;
      bus.irq_in = '0; bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_op = 2'd0;
      bus.wr_data = '0; bus.rd_addr = 2'd3; bus.ack = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_out", 32'(bus.irq_out), 32'd0);
      chk("rst_vec", 32'(bus.irq_vector), 32'd0);
      rst = 1'b0;

      // Reset state with everything unmasked
      wr(2'd0, 2'd0, 8'hFF);
      step();
      chk("t1_out", 32'(bus.irq_out), 32'd0);
      chk("t1_pend", 32'(bus.rd_data), 32'h00);

      // Two edge channels, highest first then next on ack
      wr(2'd1, 2'd0, 8'hFF);
      wr(2'd0, 2'd0, 8'h24);
      step();
      bus.irq_in = 8'h24;
      edges_until(1'b1, 3, cnt);
      bus.irq_in = '0;
      chk("t2_latency", 32'(cnt), 32'(SYNC + 2));
      chk("t2_vec5", 32'(bus.irq_vector), 32'd5);
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      step();
      chk("t2_vec2", 32'(bus.irq_vector), 32'd2);
      chk("t2_out", 32'(bus.irq_out), 32'd1);
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      step();
      chk("t2_drop", 32'(bus.irq_out), 32'd0);

      // Level channel 3: follows input, ignores ack
      wr(2'd1, 2'd0, 8'h00);
      wr(2'd0, 2'd0, 8'h08);
      step();
      bus.irq_in = 8'h08;
      edges_until(1'b1, 99, cnt);
      chk("t3_rise", 32'(cnt), 32'(SYNC + 2));
      chk("t3_vec", 32'(bus.irq_vector), 32'd3);
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      step();
      chk("t3_ack_ign", 32'(bus.irq_out), 32'd1);
      bus.irq_in = 8'h00;
      edges_until(1'b0, 99, cnt);
      chk("t3_fall", 32'(cnt), 32'(SYNC + 2));

      // Falling-edge channel 0
      bus.irq_in = 8'h01;
      repeat (4) step();
      wr(2'd2, 2'd0, 8'h01);
      wr(2'd1, 2'd0, 8'h01);
      repeat (3) step();
      chk("t4_idle", 32'(bus.rd_data[0]), 32'd0);
      bus.irq_in = 8'h00;
      repeat (4) step();
      chk("t4_set", 32'(bus.rd_data[0]), 32'd1);
      wr(2'd3, 2'd2, 8'h01);
      chk("t4_clr", 32'(bus.rd_data[0]), 32'd0);

      // Edge on channel 1 coincides with its software clear
      wr(2'd2, 2'd0, 8'h00);
      wr(2'd1, 2'd0, 8'h02);
      repeat (4) step();
      bus.irq_in = 8'h02;
      repeat (SYNC) step();
      wr(2'd3, 2'd2, 8'h02);
      chk("t5_race", 32'(bus.rd_data[1]), 32'd1);

      // Software trigger on 7, then mode toggle discards it
      bus.irq_in = 8'h00;
      wr(2'd1, 2'd1, 8'h80);
      wr(2'd3, 2'd1, 8'h80);
      wr(2'd0, 2'd0, 8'h80);
      step();
      chk("t6_out", 32'(bus.irq_out), 32'd1);
      chk("t6_vec", 32'(bus.irq_vector), 32'd7);
      wr(2'd1, 2'd3, 8'h80);
      chk("t6_modeclr", 32'(bus.rd_data[7]), 32'd0);
      step();
      chk("t6_drop", 32'(bus.irq_out), 32'd0);

      // Randomized traffic against the model, with a mid-run reset
      for (int c = 0; c < 600; c++) begin
         if (c % 3 == 0) bus.irq_in = CH'($urandom);
         bus.wr_en   = ($urandom_range(0, 2) == 0);
         bus.wr_addr = 2'($urandom);
         bus.wr_op   = 2'($urandom);
         bus.wr_data = CH'($urandom);
         bus.ack     = ($urandom_range(0, 3) == 0);
         bus.rd_addr = 2'($urandom);
         if (c == 300) begin
            rst = 1'b1;
            #1;
            chk("mid_rst_out", 32'(bus.irq_out), 32'd0);
            chk("mid_rst_mask", 32'(bus.rd_addr == 2'd0 ? bus.rd_data : 8'h00), 32'h00);
            step();
            rst = 1'b0;
         end
         step();
      end
      bus.wr_en = 1'b0; bus.ack = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised interrupt controller that gathers up to 32 asynchronous interrupt sources onto one CPU interrupt line. Each channel is synchronised, polarity-adjusted and captured as either level or sticky edge, then masked and priority-encoded to a registered vector. It sits between on-board peripherals and the CPU interrupt input. Software programs it through a small register port whose write operations are load, set, clear and toggle.

## Interface
- CHANNELS, 8, number of interrupt sources (2..32); vector width VW = $clog2(CHANNELS)
- SYNC_STAGES, 2, synchroniser depth per channel (>=2)

- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- irq_in  in  CHANNELS  raw asynchronous interrupt sources
- wr_en  in  1  register write strobe, one write per cycle
- wr_addr  in  2  0=MASK, 1=MODE (1=edge, 0=level), 2=POLARITY (1=active-low / falling edge), 3=PENDING
- wr_op  in  2  0=LOAD, 1=OR (set), 2=AND-NOT (clear), 3=XOR (toggle)
- wr_data  in  CHANNELS  write operand
- rd_addr  in  2  read select, same map as wr_addr
- rd_data  out  CHANNELS  combinational read of the selected register
- ack  in  1  acknowledge of the currently presented vector
- irq_out  out  1  registered CPU interrupt request
- irq_vector  out  VW  registered number of the highest-numbered active channel

## Operation
- Per channel: SYNC_STAGES flops, then active = sync ^ POLARITY[i], then a one-flop history for edge detection.
- Level mode: pending[i] = active each cycle; not stored; writes and ack have no effect on it.
- Edge mode: pending[i] set on a rising edge of active (history 0, active 1); sticky until cleared.
- MASK/MODE/POLARITY writes: new = op(old, wr_data) per wr_op.
- PENDING writes: OR sets edge-mode bits (software trigger); AND-NOT clears edge-mode bits (write-1-to-clear); LOAD and XOR are ignored.
- A MODE write clears pending for every channel whose mode bit changes. This clear wins over an edge detected in the same cycle.
- ack with irq_out=1 clears pending[irq_vector] if that channel is in edge mode. ack with irq_out=0 is ignored.
- An edge detected in the same cycle as a software clear or ack of the same bit: set wins, so no event is lost.
- rd_data returns the register for addresses 0-2. Address 3 returns effective pending (level and edge combined), before masking.
- Request = pending & MASK. irq_out = |request. irq_vector = index of the highest set bit of request, or 0 when there is none.
- Changing POLARITY can create an edge. Software clears PENDING after any polarity change; the block does not suppress this edge.

## Timing
- Reset values: MASK, MODE, POLARITY, PENDING, sync and history flops = 0; irq_out = 0; irq_vector = 0. Reset selects level mode, active-high, all channels masked.
- Reset asserted mid-operation clears all state immediately. The first new edge after release needs full synchroniser latency.
- irq_in stable before edge N: sync output valid after edge N+SYNC_STAGES-1; edge-mode pending set at edge N+SYNC_STAGES; irq_out and irq_vector valid after edge N+SYNC_STAGES+1.
- Level mode: irq_out follows irq_in with the same latency on both assertion and deassertion.
- Register write at edge N: the new value is visible on rd_data after edge N and affects irq_out after edge N+1.
- ack at edge N: the pending bit clears at edge N; irq_out and irq_vector update at edge N+1, showing the next channel or dropping.
- Input pulses shorter than one clock period may be missed. Sources must hold their level for at least 2 clocks.

## Structure
- Shared package irq_pkg holds:
  - register address constants REG_MASK, REG_MODE, REG_POLARITY, REG_PENDING
  - op codes OP_LOAD, OP_SET, OP_CLEAR, OP_XOR
- Sub-module irq_channel: synchroniser, polarity, edge detect and pending flop with set/clear/mode inputs. Instantiated CHANNELS times with a generate loop.
- The top level holds the config registers, write ALU, read mux, priority encoder and output registers.

## Test plan
- Reset, then irq_in=8'h00, MASK=8'hFF, all other registers at reset -> irq_out=0, irq_vector=0, rd_data(PENDING)=8'h00.
- MODE=8'hFF, MASK=8'h24, pulse irq_in[2] and irq_in[5] high for 3 clocks together -> irq_out rises SYNC_STAGES+1 edges after sampling with irq_vector=5; ack -> vector 2 next cycle; second ack -> irq_out=0.
- Level channel 3 with MASK=8'h08: hold irq_in[3]=1 -> irq_out=1, vector=3; ack has no effect; drop irq_in[3] -> irq_out=0 after SYNC_STAGES+1 edges.
- POLARITY=8'h01, MODE=8'h01, irq_in[0] idle high, then falls -> pending[0]=1; PENDING write AND-NOT 8'h01 -> cleared.
- Edge on channel 1 arrives in the same cycle as PENDING AND-NOT 8'h02 -> pending[1] stays 1.
- MODE write XOR 8'h80 while pending[7]=1 -> pending[7]=0. PENDING OR 8'h80 with MODE[7]=1, MASK[7]=1 -> irq_out=1, vector=7.
